// File: rtl/rr_mux_arbiter_pkg.sv
// ============================================================================
// Module      : rr_mux_arbiter_pkg
// Description : Shared types and constants for the round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_mux_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Encodes a one-hot (or all-zero) grant into a requester index.
  function automatic req_id_t onehot_to_id(input logic [N_REQ-1:0] oh);
    req_id_t id;
    id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) id = id | req_id_t'(i);
    end
    return id;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_pick4.sv
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin pick starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  req_id_t          ptr,
  output logic [N_REQ-1:0] gnt_oh
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [2*N_REQ-1:0] w_base;
  logic [2*N_REQ-1:0] w_masked;

  // Subtracting the ptr bit isolates the first set bit at or above ptr;
  // the upper copy of the request covers the wrap-around case.
  assign w_dbl    = {req, req};
  assign w_base   = (2*N_REQ)'(1) << ptr;
  assign w_masked = w_dbl & ~(w_dbl - w_base);
  assign gnt_oh   = w_masked[N_REQ-1:0] | w_masked[2*N_REQ-1:N_REQ];

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module      : rr_mux_arbiter
// Description : 4-requester round-robin arbiter with AND-OR data select and
//               a one-deep registered output stage tagged with source index.
//               Optional packet lock enabled by RR_MUX_ARBITER_LAST_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int W = 4
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  output logic [N_REQ-1:0] in_ready,
`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
  input  logic [N_REQ-1:0] in_last,
  output logic             out_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output req_id_t          out_id
);

  logic [W-1:0]     w_d    [N_REQ];
  logic [W-1:0]     w_term [N_REQ];
  logic [W-1:0]     w_sel;
  logic [N_REQ-1:0] w_rr_gnt;
  logic [N_REQ-1:0] w_gnt;
  logic             w_load;
  logic             w_accept;
  logic             w_ptr_upd;
  req_id_t          w_gnt_id;

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  req_id_t          r_out_id;
  req_id_t          r_ptr;

  assign w_d[0] = d0;
  assign w_d[1] = d1;
  assign w_d[2] = d2;
  assign w_d[3] = d3;

  rr_pick4 u_pick (
    .req    (in_valid),
    .ptr    (r_ptr),
    .gnt_oh (w_rr_gnt)
  );

  assign w_load   = ~r_out_valid | out_ready;
  assign in_ready = w_gnt & {N_REQ{w_load}} & {N_REQ{~rst}};
  assign w_accept = |(in_valid & in_ready);
  assign w_gnt_id = onehot_to_id(w_gnt);

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
      assign w_term[gi] = w_d[gi] & {W{w_gnt[gi]}};
    end
  endgenerate

  assign w_sel = w_term[0] | w_term[1] | w_term[2] | w_term[3];

`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
  arb_state_t r_state;
  arb_state_t w_state_nxt;
  req_id_t    r_lock_id;
  logic       r_out_last;
  logic [N_REQ-1:0] w_lock_oh;

  assign w_lock_oh = N_REQ'(1) << r_lock_id;

  // While locked only the owning requester may be granted.
  always_comb begin
    w_gnt = w_rr_gnt;
    if (r_state == LOCK) w_gnt = in_valid & w_lock_oh;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_upd   = 1'b0;
    case (r_state)
      ARB: begin
        if (w_accept) begin
          if (in_last[w_gnt_id]) w_ptr_upd   = 1'b1;
          else                   w_state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (w_accept && in_last[r_lock_id]) begin
          w_state_nxt = ARB;
          w_ptr_upd   = 1'b1;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB;
      r_lock_id  <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB && w_state_nxt == LOCK) r_lock_id <= w_gnt_id;
      if (w_accept) r_out_last <= in_last[w_gnt_id];
    end
  end

  assign out_last = r_out_last;
`else
  assign w_gnt     = w_rr_gnt;
  assign w_ptr_upd = w_accept;
`endif

  // A new beat overwrites the slot even when it drains in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel;
        r_out_id    <= w_gnt_id;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_ptr_upd) r_ptr <= req_id_t'(w_gnt_id + req_id_t'(1));
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Scoreboard bench for rr_mux_arbiter with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   id;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_id;
`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
  logic [3:0]   in_last;
  logic         out_last;
`endif

  beat_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  int    m_ptr;
  logic  m_valid;

  rr_mux_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: the presented beat must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected actual=id%0d required=none", out_id);
      end else begin
        chk("out_data", 32'(out_data), 32'(sb[0].data));
        chk("out_id", 32'(out_id), 32'(sb[0].id));
`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
        chk("out_last", 32'(out_last), 32'(sb[0].last));
`endif
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // One cycle of stimulus; dd packs {d3,d2,d1,d0}.
  task automatic step(input logic [3:0] v, input logic r, input logic [4*W-1:0] dd);
    int         g;
    logic       load;
    logic [3:0] one;
    logic [3:0] exp_rdy;
    beat_t      b;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    in_valid  = v;
    out_ready = r;
    d0 = dd[0*W +: W];
    d1 = dd[1*W +: W];
    d2 = dd[2*W +: W];
    d3 = dd[3*W +: W];
`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
    in_last = 4'hF;
`endif
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    load    = !m_valid || r;
    one     = 4'b0001;
    exp_rdy = (g >= 0 && load) ? (one << g) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      b.data = dd[g*W +: W];
      b.id   = 2'(g);
      b.last = 1'b1;
      sb.push_back(b);
      m_ptr   = (g + 1) % 4;
      m_valid = 1'b1;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic hard_reset();
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_ptr   = 0;
    m_valid = 1'b0;
  endtask

`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
  task automatic lstep(input logic [3:0] v, input logic [3:0] last, input int exp_id);
    logic [3:0] one;
    logic [W-1:0] dv [4];
    beat_t b;
    @(posedge clk);
    #1;
    chk("lock_out_valid", 32'(out_valid), 32'(m_valid));
    for (int i = 0; i < 4; i++) dv[i] = W'($urandom);
    in_valid  = v;
    in_last   = last;
    out_ready = 1'b1;
    d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
    #1;
    one = 4'b0001;
    chk("lock_in_ready", 32'(in_ready), 32'(one << exp_id));
    b.data = dv[exp_id];
    b.id   = 2'(exp_id);
    b.last = last[exp_id];
    sb.push_back(b);
    m_valid = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
    in_last = 4'hF;
`endif
    m_ptr = 0;
    m_valid = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
    chk("rst_out_last", 32'(out_last), 32'd0);
`endif
    in_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    // Single requester, then sparse 1001 alternation and idle cycles.
    step(4'b0100, 1'b1, {8'h11, 8'hA5, 8'h22, 8'h33});
    for (int i = 0; i < 4; i++) step(4'b1001, 1'b1, 32'($urandom));
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 32'($urandom));
    step(4'b1001, 1'b1, 32'($urandom));

    // Backpressure with all requesters valid.
    step(4'b1111, 1'b1, 32'($urandom));
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 32'($urandom));
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 32'($urandom));

    // Randomised traffic with varying request density and backpressure.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      v = 4'($urandom);
      if ($urandom_range(0, 3) == 0) v = 4'b1111;
      step(v, ($urandom_range(0, 3) != 0), 32'($urandom));
    end

    // Reset while a beat is held in the output register.
    step(4'b1111, 1'b1, 32'($urandom));
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    #1;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    sb.delete();
    m_ptr = 0;
    m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 32'($urandom));

`ifdef RR_MUX_ARBITER_LAST_LOCK_EN
    hard_reset();
    lstep(4'b0110, 4'b0000, 1);
    lstep(4'b0110, 4'b0000, 1);
    lstep(4'b0110, 4'b0010, 1);
    lstep(4'b0110, 4'b0110, 2);
    m_ptr = 3;
`endif

    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 32'($urandom));
    @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one W-bit 4:1 selector datapath between four valid/ready requesters.
- Picks one requester per transfer and routes its data through an AND-OR select structure into a one-deep registered output stage.
- Tags each output beat with the source index.
- Sits between four producer streams and a single downstream consumer.

Parameters:
- W, 4, data width of each requester and of the output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- d0, d1, d2, d3  input  W each  requester data.
- in_ready  output  4  per-requester ready, combinational; at most one bit is set.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts.
- out_data  output  W  registered selected data.
- out_id  output  2  index of the requester that supplied out_data.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_id=0.
  - Priority pointer ptr=0, so requester 0 has the highest priority.
  - in_ready=0 while rst=1.
- load = ~out_valid | out_ready. The output slot is free, or is being drained this cycle.
- Grant, combinational: the first requester with in_valid set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - gnt_oh is 4-bit one-hot, all zero if no valid.
  - in_ready = gnt_oh & {4{load}}.
- Select: the data mux is built from gnt_oh only, as OR over i of (di & {W{gnt_oh[i]}}). No behavioural case statement.
- Accept occurs when any in_valid[i] & in_ready[i]. On the next edge:
  - out_data <= selected data, out_id <= granted index, out_valid <= 1.
  - ptr <= granted index + 1, wrapping 3 -> 0.
- If out_valid & out_ready and there is no accept: out_valid <= 0. out_data and out_id hold their values.
- Simultaneous drain and accept: out_valid stays 1 and the new beat replaces the old one. Full throughput is 1 beat/cycle.
- Latency: 1 cycle from accept to out_valid.
- Backpressure (out_valid=1, out_ready=0):
  - in_ready=0.
  - out_data and out_id stay stable.
  - ptr does not change.
- ptr changes only on accept. Idle cycles do not rotate priority.
- No request is dropped. A requester that keeps in_valid asserted is served within 4 accepts.
- in_valid may drop without a handshake. The grant recomputes each cycle.
- Reset mid-transfer clears the output beat immediately. No partial state survives.

Optional Feature:
- Macro: RR_MUX_ARBITER_LAST_LOCK_EN.
- Defined:
  - Adds ports in_last (input, 4) and out_last (output, 1; reset 0).
  - Two-state FSM:
    - ARB: normal round-robin grant.
    - LOCK: grant is forced to the locked index (lock_id) only. The other requesters see in_ready=0.
  - ARB -> LOCK on accept with in_last[g]=0; lock_id <= g.
  - LOCK -> ARB on accept with in_last[lock_id]=1.
  - ptr updates only when the LOCK -> ARB exit accept happens, or on a single-beat accept in ARB.
  - out_last is registered alongside out_data.
  - Reset returns the FSM to ARB.
- Not defined: no last ports, and every beat re-arbitrates.

Decomposition:
- Shared package rr_mux_arbiter_pkg holds:
  - localparam N_REQ = 4 and ID_W = 2.
  - The typedef req_id_t (logic [ID_W-1:0]).
  - Enum arb_state_t {ARB, LOCK}.
- One sub-module, rr_pick4: inputs req[3:0] and ptr; output gnt_oh[3:0]. It is purely combinational, implemented by doubling the request vector and masking.

Test Plan:
- Single requester: in_valid=4'b0100, d2=8'hA5, out_ready=1.
  - Expect in_ready=4'b0100.
  - Next cycle: out_valid=1, out_data=A5, out_id=2, and ptr becomes 3.
- All four valid continuously, out_ready=1, after reset.
  - Expect out_id sequence 0,1,2,3,0,1 with one beat per cycle and no bubbles.
- Sparse requests: in_valid=4'b1001 with ptr=1.
  - Expect grant to 3, then to 0, then to 3 (alternating).
  - Idle cycles with in_valid=0 leave ptr unchanged.
- Backpressure: hold out_ready=0 for 3 cycles with all valid.
  - Expect in_ready=0, out_data/out_id frozen.
  - After release, resumes with the next round-robin index.
- Reset mid-stream: assert rst while out_valid=1.
  - Expect out_valid=0 and out_data=0 asynchronously (before the next edge).
  - After release, the first grant goes to requester 0 when all are valid.
- Lock (with RR_MUX_ARBITER_LAST_LOCK_EN): requester 1 sends 3 beats, last on the 3rd, while requester 2 is valid.
  - Expect out_id=1,1,1 and out_last=0,0,1, then out_id=2.
